// File: rtl/tsmac_fifo_pkg.sv
// Shared definitions for the TSMAC loopback FIFO word format and framer states.
package tsmac_fifo_pkg;

    localparam int unsigned WORD_LAST     = 8;
    localparam int unsigned WORD_ERR      = 9;
    localparam int unsigned WORD_W        = 18;

    localparam int unsigned DEF_MIN_LEN   = 60;
    localparam int unsigned DEF_MAX_LEN   = 1518;
    localparam int unsigned DEF_SYNC_IDLE = 12;

    typedef enum logic [1:0] {
        RX_SYNC = 2'b00,
        RX_IDLE = 2'b01,
        RX_DATA = 2'b10,
        RX_DROP = 2'b11
    } rx_state_e;

    function automatic logic [WORD_W-1:0] mk_word(input logic [7:0] b,
                                                  input logic       last,
                                                  input logic       err);
        return {8'h00, err, last, b};
    endfunction

endpackage

// File: rtl/rx_sm_sat_cnt16.sv
// 16-bit counter that increments on en&inc and sticks at 16'hFFFF.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rx_sm.sv
// Receive framer: TSMAC receive bytes -> 18-bit loopback FIFO words, with
// frame length checks, drop handling and a frame-done pulse for the tx side.
module rx_sm
    import tsmac_fifo_pkg::*;
#(
    parameter int unsigned MIN_LEN   = DEF_MIN_LEN,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
    parameter int unsigned SYNC_IDLE = DEF_SYNC_IDLE
) (
    input  logic              rx_clk,
    input  logic              rst_n,
    input  logic              clk_ten,
    input  logic [7:0]        tsmac_rdata,
    input  logic              tsmac_rvalid,
    input  logic              tsmac_rlast,
    input  logic              tsmac_rgood,
    input  logic              tsmac_rbad,
    input  logic              fifo_afull,
    output logic              wr_en,
    output logic [WORD_W-1:0] wr_data,
    output logic              rx_frame_done,
    output logic [15:0]       good_frame_cnt,
    output logic [15:0]       drop_frame_cnt
);

    localparam int unsigned     SYNC_W    = $clog2(SYNC_IDLE + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_IDLE - 1);
    localparam logic [10:0]     MIN_L     = 11'(MIN_LEN);
    localparam logic [10:0]     MAX_L1    = 11'(MAX_LEN + 1);

    rx_state_e         state_q, state_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [10:0]       len_q, len_d, len_inc;
    logic              wr_en_q, wr_en_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              drop_inc;
    logic              frame_err;

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        len_d      = len_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        drop_inc   = 1'b0;
        len_inc    = (len_q == '1) ? len_q : len_q + 11'd1;
        frame_err  = tsmac_rbad | ~tsmac_rgood | (len_inc < MIN_L) |
                     fifo_afull | (len_inc == MAX_L1);

        unique case (state_q)
            RX_SYNC: begin
                if (tsmac_rvalid) begin
                    sync_cnt_d = '0;
                    if (tsmac_rlast) state_d = RX_IDLE;
                end else if (sync_cnt_q == SYNC_LAST) begin
                    sync_cnt_d = '0;
                    state_d    = RX_IDLE;
                end else begin
                    sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                end
            end
            RX_IDLE: begin
                if (tsmac_rvalid) begin
                    if (tsmac_rlast) begin
                        // 1-byte frame is always a runt terminator
                        wr_en_d   = 1'b1;
                        wr_data_d = mk_word(tsmac_rdata, 1'b1, 1'b1);
                        drop_inc  = 1'b1;
                        len_d     = '0;
                    end else if (fifo_afull) begin
                        drop_inc = 1'b1;
                        state_d  = RX_DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = mk_word(tsmac_rdata, 1'b0, 1'b0);
                        len_d     = 11'd1;
                        state_d   = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tsmac_rvalid) begin
                    len_d   = len_inc;
                    wr_en_d = 1'b1;
                    if (tsmac_rlast) begin
                        wr_data_d = mk_word(tsmac_rdata, 1'b1, frame_err);
                        drop_inc  = frame_err;
                        state_d   = RX_IDLE;
                    end else if (fifo_afull || (len_inc == MAX_L1)) begin
                        wr_data_d = mk_word(tsmac_rdata, 1'b1, 1'b1);
                        drop_inc  = 1'b1;
                        state_d   = RX_DROP;
                    end else begin
                        wr_data_d = mk_word(tsmac_rdata, 1'b0, 1'b0);
                    end
                end
            end
            RX_DROP: begin
                if (tsmac_rvalid && tsmac_rlast) state_d = RX_IDLE;
            end
            default: state_d = RX_SYNC;
        endcase

        // frame-done trails the good terminator write by one enabled cycle
        done_d = wr_en_q & wr_data_q[WORD_LAST] & ~wr_data_q[WORD_ERR];
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q    <= RX_SYNC;
            sync_cnt_q <= '0;
            len_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else if (clk_ten) begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            len_q      <= len_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

    sat_cnt16 u_good_cnt (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .en    (clk_ten),
        .inc   (done_d),
        .cnt   (good_frame_cnt)
    );

    sat_cnt16 u_drop_cnt (
        .clk   (rx_clk),
        .rst_n (rst_n),
        .en    (clk_ten),
        .inc   (drop_inc),
        .cnt   (drop_frame_cnt)
    );

    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign rx_frame_done = done_q;

endmodule

// File: tb/tb_rx_sm.sv
// Directed bench for rx_sm: frames of varying length/status, FIFO back-pressure,
// oversize frames, mid-frame reset release and a 1-in-10 clock enable.
module tb_rx_sm;

    logic        rx_clk = 1'b0;
    logic        rst_n;
    logic        clk_ten;
    logic [7:0]  tsmac_rdata;
    logic        tsmac_rvalid;
    logic        tsmac_rlast;
    logic        tsmac_rgood;
    logic        tsmac_rbad;
    logic        fifo_afull;
    logic        wr_en;
    logic [17:0] wr_data;
    logic        rx_frame_done;
    logic [15:0] good_frame_cnt;
    logic [15:0] drop_frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int div    = 1;

    logic [17:0] words[$];
    int          done_pulses = 0;
    int          done_hi     = 0;

    always #5 rx_clk = ~rx_clk;

    rx_sm #(.MIN_LEN(60), .MAX_LEN(1518), .SYNC_IDLE(12)) dut (
        .rx_clk         (rx_clk),
        .rst_n          (rst_n),
        .clk_ten        (clk_ten),
        .tsmac_rdata    (tsmac_rdata),
        .tsmac_rvalid   (tsmac_rvalid),
        .tsmac_rlast    (tsmac_rlast),
        .tsmac_rgood    (tsmac_rgood),
        .tsmac_rbad     (tsmac_rbad),
        .fifo_afull     (fifo_afull),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rx_frame_done  (rx_frame_done),
        .good_frame_cnt (good_frame_cnt),
        .drop_frame_cnt (drop_frame_cnt)
    );

    // inputs change 1 ns after posedge, so the negedge view is what the next edge uses
    always @(negedge rx_clk) begin
        if (wr_en && clk_ten) words.push_back(wr_data);
        if (rx_frame_done) begin
            done_hi++;
            if (clk_ten) done_pulses++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                       input logic g, input logic b, input logic af);
        tsmac_rvalid = v;
        tsmac_rdata  = v ? d : 8'h00;
        tsmac_rlast  = v & l;
        tsmac_rgood  = g;
        tsmac_rbad   = b;
        fifo_afull   = af;
        for (int k = 0; k < div; k++) begin
            clk_ten = (k == div - 1);
            @(posedge rx_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input logic good, input logic bad, input int af_at);
        for (int i = 0; i < n; i++) begin
            logic l;
            l = (i == n - 1);
            cyc(1'b1, 8'(i), l, good & l, bad & l, (af_at >= 0) && (i >= af_at));
        end
    endtask

    initial begin
        int st, dp, nl;
        rst_n = 1'b0; clk_ten = 1'b1; fifo_afull = 1'b0;
        tsmac_rdata = '0; tsmac_rvalid = 1'b0; tsmac_rlast = 1'b0;
        tsmac_rgood = 1'b0; tsmac_rbad = 1'b0;
        repeat (3) @(posedge rx_clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_done", 32'(rx_frame_done), 32'h0);
        chk("rst_good", 32'(good_frame_cnt), 32'h0);
        chk("rst_drop", 32'(drop_frame_cnt), 32'h0);
        rst_n = 1'b1;
        idle(12);

        // 1: 64-byte good frame
        st = words.size(); dp = done_pulses;
        send_frame(64, 1'b1, 1'b0, -1);
        idle(4);
        chk("t1_writes", 32'(words.size() - st), 32'd64);
        chk("t1_w0", 32'(words[st]), 32'h0);
        chk("t1_w62", 32'(words[st+62]), 32'h03E);
        chk("t1_w63", 32'(words[st+63]), 32'h13F);
        nl = 0;
        for (int i = st; i < words.size(); i++) if (words[i][8]) nl++;
        chk("t1_last_cnt", 32'(nl), 32'd1);
        chk("t1_done", 32'(done_pulses - dp), 32'd1);
        chk("t1_good", 32'(good_frame_cnt), 32'd1);
        chk("t1_drop", 32'(drop_frame_cnt), 32'd0);

        // 2: 40-byte runt
        st = words.size(); dp = done_pulses;
        send_frame(40, 1'b1, 1'b0, -1);
        idle(4);
        chk("t2_writes", 32'(words.size() - st), 32'd40);
        chk("t2_w39", 32'(words[st+39]), 32'h327);
        chk("t2_done", 32'(done_pulses - dp), 32'd0);
        chk("t2_drop", 32'(drop_frame_cnt), 32'd1);

        // 3: 100-byte frame with rbad
        st = words.size(); dp = done_pulses;
        send_frame(100, 1'b1, 1'b1, -1);
        idle(4);
        chk("t3_writes", 32'(words.size() - st), 32'd100);
        chk("t3_w99", 32'(words[st+99]), 32'h363);
        chk("t3_good", 32'(good_frame_cnt), 32'd1);
        chk("t3_drop", 32'(drop_frame_cnt), 32'd2);
        chk("t3_done", 32'(done_pulses - dp), 32'd0);

        // 4: afull from byte 20 of a 200-byte frame, then a normal frame
        st = words.size();
        send_frame(200, 1'b1, 1'b0, 19);
        idle(4);
        chk("t4_writes", 32'(words.size() - st), 32'd20);
        chk("t4_w19", 32'(words[st+19]), 32'h313);
        chk("t4_w18", 32'(words[st+18]), 32'h012);
        chk("t4_drop", 32'(drop_frame_cnt), 32'd3);
        st = words.size(); dp = done_pulses;
        send_frame(64, 1'b1, 1'b0, -1);
        idle(4);
        chk("t4b_writes", 32'(words.size() - st), 32'd64);
        chk("t4b_w63", 32'(words[st+63]), 32'h13F);
        chk("t4b_done", 32'(done_pulses - dp), 32'd1);
        chk("t4b_good", 32'(good_frame_cnt), 32'd2);

        // 5: 1600-byte oversize frame
        st = words.size();
        send_frame(1600, 1'b1, 1'b0, -1);
        idle(4);
        chk("t5_writes", 32'(words.size() - st), 32'd1519);
        chk("t5_w1517", 32'(words[st+1517]), 32'h0ED);
        chk("t5_w1518", 32'(words[st+1518]), 32'h3EE);
        chk("t5_drop", 32'(drop_frame_cnt), 32'd4);
        chk("t5_good", 32'(good_frame_cnt), 32'd2);

        // 6: reset released at byte 30 of a 100-byte frame
        st = words.size();
        for (int i = 0; i < 100; i++) begin
            logic l;
            l = (i == 99);
            rst_n = (i >= 30);
            cyc(1'b1, 8'(i), l, l, 1'b0, 1'b0);
        end
        idle(3);
        chk("t6_writes", 32'(words.size() - st), 32'd0);
        chk("t6_good", 32'(good_frame_cnt), 32'd0);
        chk("t6_drop", 32'(drop_frame_cnt), 32'd0);
        st = words.size(); dp = done_pulses;
        send_frame(64, 1'b1, 1'b0, -1);
        idle(4);
        chk("t6b_writes", 32'(words.size() - st), 32'd64);
        chk("t6b_w63", 32'(words[st+63]), 32'h13F);
        chk("t6b_good", 32'(good_frame_cnt), 32'd1);

        // 6c: reset with clk_ten=0, then 1-in-10 enable
        clk_ten = 1'b0; rst_n = 1'b0;
        @(posedge rx_clk);
        #1;
        chk("t7_rst_noen", 32'(good_frame_cnt), 32'd0);
        rst_n = 1'b1;
        div = 10;
        idle(12);
        st = words.size(); dp = done_pulses;
        send_frame(64, 1'b1, 1'b0, -1);
        idle(4);
        chk("t7_writes", 32'(words.size() - st), 32'd64);
        chk("t7_w0", 32'(words[st]), 32'h0);
        chk("t7_w63", 32'(words[st+63]), 32'h13F);
        chk("t7_done", 32'(done_pulses - dp), 32'd1);
        chk("t7_good", 32'(good_frame_cnt), 32'd1);

        // done_hi accumulates 1 per earlier good frame plus 10 for this one
        chk("t7_done_span", 32'(done_hi), 32'd13);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
